// File: rtl/ip_scc_sound_dac_pkg.sv
// Shared constants and ramp-FSM encoding for the SCC sound DAC back end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ip_scc_sound_dac_pkg;

  localparam int DEF_SOUND_WIDTH = 11;  // signed SCC sample
  localparam int DEF_LEVEL_WIDTH = 16;  // signed scaled level / DAC data path
  localparam int VOLUME_WIDTH    = 4;   // unsigned volume 0..15
  localparam int GAIN_WIDTH      = 5;   // unsigned ramp gain 0..16
  localparam int GAIN_MAX        = 16;  // unity gain after the >>> GAIN_SHIFT
  localparam int GAIN_SHIFT      = 4;

  typedef enum logic [1:0] {
    ST_MUTED     = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/ip_scc_sound_dac_if.sv
// Sample/control/output bundle between the SCC wrapper and the sound DAC.
// Latency: n/a (wires only).
// Backpressure: none; sample_en is a one-clk strobe, outputs are free-running.
// Ports: sample_en, sound_in, volume, mute (master -> slave);
//        level_out, dac_out, ramp_busy (slave -> master).
interface ip_scc_sound_dac_if
  import ip_scc_sound_dac_pkg::*;
#(
  parameter int SOUND_WIDTH = DEF_SOUND_WIDTH,
  parameter int LEVEL_WIDTH = DEF_LEVEL_WIDTH
);

  logic                          sample_en;
  logic signed [SOUND_WIDTH-1:0] sound_in;
  logic [VOLUME_WIDTH-1:0]       volume;
  logic                          mute;
  logic signed [LEVEL_WIDTH-1:0] level_out;
  logic                          dac_out;
  logic                          ramp_busy;

  modport master (
    output sample_en, sound_in, volume, mute,
    input  level_out, dac_out, ramp_busy
  );

  modport slave (
    input  sample_en, sound_in, volume, mute,
    output level_out, dac_out, ramp_busy
  );

endinterface

// File: rtl/ip_delta_sigma_1st.sv
// First-order delta-sigma 1-bit DAC; ones density of dac_out = u / 2^WIDTH.
// Latency: level change visible on dac_out 2 clk later (accumulator, then output flop).
// Backpressure: none; runs every clk.
// Ports: clk, reset (sync, active-high), level (signed, in), dac_out (out).
module ip_delta_sigma_1st
  import ip_scc_sound_dac_pkg::*;
#(
  parameter int WIDTH = DEF_LEVEL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic             dac_out
);

  localparam logic [WIDTH-1:0] OFFSET = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] u;

  // Flipping the sign bit turns two's complement into offset binary,
  // so a zero level sits at mid-scale (50% ones).
  assign u = level ^ OFFSET;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else begin
      // The carry out of the previous sum is the output bit; it is dropped
      // from the running sum, which is the first-order noise-shaping step.
      acc     <= {1'b0, acc[WIDTH-1:0]} + {1'b0, u};
      dac_out <= acc[WIDTH];
    end
  end

endmodule

// File: rtl/ip_scc_sound_dac.sv
// SCC audio back end: capture, volume, click-free mute ramp, 1-bit delta-sigma DAC.
// Latency: sample_en -> level_out 3 clk; level_out -> dac_out 2 clk more.
// Backpressure: none; one sample per sample_en strobe, pipeline runs every clk.
// Ports: clk, reset (sync, active-high), bus (slave modport: sample_en,
//        sound_in, volume, mute in; level_out, dac_out, ramp_busy out).
module ip_scc_sound_dac
  import ip_scc_sound_dac_pkg::*;
#(
  parameter int SOUND_WIDTH = DEF_SOUND_WIDTH,
  parameter int LEVEL_WIDTH = DEF_LEVEL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  ip_scc_sound_dac_if.slave  bus
);

  localparam int P1_WIDTH = SOUND_WIDTH + VOLUME_WIDTH;  // sample * volume
  localparam int P2_WIDTH = P1_WIDTH + GAIN_WIDTH;       // * gain, before shift

  localparam logic [GAIN_WIDTH-1:0] GAIN_TOP = GAIN_WIDTH'(GAIN_MAX);
  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(1);

  ramp_state_t                   state;
  logic [GAIN_WIDTH-1:0]         gain;
  logic                          ramp_busy_q;
  logic signed [SOUND_WIDTH-1:0] ff_sample;
  logic signed [P1_WIDTH-1:0]    ff_p1;
  logic signed [LEVEL_WIDTH-1:0] level_q;
  logic signed [P1_WIDTH-1:0]    p1_next;
  logic signed [P2_WIDTH-1:0]    p2_prod;

  // Volume and gain are unsigned; a zero MSB makes them signed-positive so
  // both products are true signed multiplies. The product widths are large
  // enough that no term ever wraps.
  always_comb begin
    p1_next = P1_WIDTH'(ff_sample) * P1_WIDTH'($signed({1'b0, bus.volume}));
    p2_prod = P2_WIDTH'(ff_p1) * P2_WIDTH'($signed({1'b0, gain}));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_sample <= '0;
      ff_p1     <= '0;
      level_q   <= '0;
    end else begin
      if (bus.sample_en) begin
        ff_sample <= bus.sound_in;
      end
      ff_p1   <= p1_next;
      // Arithmetic shift floors toward -inf; the result always fits LEVEL_WIDTH.
      level_q <= LEVEL_WIDTH'(p2_prod >>> GAIN_SHIFT);
    end
  end

  // Ramp FSM. A direction change wins over a sample step on the same edge.
  // The gain==bound guards only matter after a reversal that happened before
  // any step, and keep gain inside 0..GAIN_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_MUTED;
      gain        <= '0;
      ramp_busy_q <= 1'b0;
    end else begin
      case (state)
        ST_MUTED: begin
          if (!bus.mute) begin
            state       <= ST_RAMP_UP;
            ramp_busy_q <= 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (bus.mute) begin
            state <= ST_RAMP_DOWN;
          end else if (gain == GAIN_TOP) begin
            state       <= ST_ACTIVE;
            ramp_busy_q <= 1'b0;
          end else if (bus.sample_en) begin
            gain <= gain + GAIN_ONE;
            if (gain == GAIN_TOP - GAIN_ONE) begin
              state       <= ST_ACTIVE;
              ramp_busy_q <= 1'b0;
            end
          end
        end
        ST_ACTIVE: begin
          if (bus.mute) begin
            state       <= ST_RAMP_DOWN;
            ramp_busy_q <= 1'b1;
          end
        end
        ST_RAMP_DOWN: begin
          if (!bus.mute) begin
            state <= ST_RAMP_UP;
          end else if (gain == '0) begin
            state       <= ST_MUTED;
            ramp_busy_q <= 1'b0;
          end else if (bus.sample_en) begin
            gain <= gain - GAIN_ONE;
            if (gain == GAIN_ONE) begin
              state       <= ST_MUTED;
              ramp_busy_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.level_out = level_q;
  assign bus.ramp_busy = ramp_busy_q;

  ip_delta_sigma_1st #(
    .WIDTH (LEVEL_WIDTH)
  ) u_dac (
    .clk     (clk),
    .reset   (reset),
    .level   (level_q),
    .dac_out (bus.dac_out)
  );

endmodule

// File: tb/tb_ip_scc_sound_dac.sv
// Self-checking bench for ip_scc_sound_dac: hand sequences, a vector table
// in ACTIVE, a density count and randomized traffic against a reference model.
// Inputs change #1 after posedge; outputs are compared at that same point.
module tb_ip_scc_sound_dac;

  logic clk = 1'b0;
  logic reset;

  ip_scc_sound_dac_if bus();

  ip_scc_sound_dac dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // Ramp described as "gain walks toward a goal (0 or 16) one step per
  // sample; a changed goal costs one edge with no step".
  typedef struct packed {
    int   gain;
    int   goal;
    logic busy;
  } ramp_t;

  function automatic ramp_t ramp_next(ramp_t r, logic mute_i, logic se);
    ramp_t n;
    int    want;
    n    = r;
    want = mute_i ? 0 : 16;
    if (want != r.goal) begin
      n.goal = want;
      n.busy = 1'b1;
    end else if (r.busy) begin
      if (r.gain == r.goal) begin
        n.busy = 1'b0;
      end else if (se) begin
        n.gain = r.gain + ((r.goal > r.gain) ? 1 : -1);
        n.busy = (n.gain != n.goal);
      end
    end
    return n;
  endfunction

  ramp_t m_ramp;
  int    m_sample, m_p1, m_level, m_acc;
  logic  m_dac;

  always @(posedge clk) begin
    if (reset) begin
      m_sample <= 0;
      m_p1     <= 0;
      m_level  <= 0;
      m_acc    <= 0;
      m_dac    <= 1'b0;
      m_ramp   <= '0;
    end else begin
      if (bus.sample_en) m_sample <= int'(bus.sound_in);
      m_p1    <= m_sample * int'(bus.volume);
      // >>> on a signed int is floor division by 16
      m_level <= (m_p1 * m_ramp.gain) >>> 4;
      // offset-binary code is level + 32768; carry is "sum >= 65536"
      m_acc   <= (m_acc % 65536) + (m_level + 32768);
      m_dac   <= (m_acc >= 65536);
      m_ramp  <= ramp_next(m_ramp, bus.mute, bus.sample_en);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; every cycle is also compared against the model.
  task automatic step();
    @(posedge clk);
    #1;
    tests++;
    if ($signed(bus.level_out) !== m_level || bus.dac_out !== m_dac ||
        bus.ramp_busy !== m_ramp.busy) begin
      fails++;
      $display("FAIL model t=%0t: level %0d exp %0d, dac %b exp %b, busy %b exp %b",
               $time, $signed(bus.level_out), m_level, bus.dac_out, m_dac,
               bus.ramp_busy, m_ramp.busy);
    end
  endtask

  task automatic pulse();
    bus.sample_en = 1'b1;
    step();
    bus.sample_en = 1'b0;
  endtask

  typedef struct {
    int snd;
    int vol;
    int lvl;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n;
    int ones;

    vecs[0] = '{1023, 15, 15345};
    vecs[1] = '{-1024, 15, -15360};
    vecs[2] = '{-1, 1, -1};
    vecs[3] = '{0, 15, 0};
    vecs[4] = '{100, 3, 300};
    vecs[5] = '{-100, 7, -700};
    vecs[6] = '{511, 0, 0};
    vecs[7] = '{-512, 8, -4096};
    vecs[8] = '{1, 1, 1};

    reset         = 1'b1;
    bus.sample_en = 1'b0;
    bus.sound_in  = '0;
    bus.volume    = '0;
    bus.mute      = 1'b1;

    // reset values
    step();
    check("rst_level", $signed(bus.level_out), 0);
    check("rst_dac", bus.dac_out, 0);
    check("rst_busy", bus.ramp_busy, 0);
    step();

    // ramp up from reset with silent input
    reset        = 1'b0;
    bus.mute     = 1'b0;
    bus.volume   = 4'd15;
    bus.sound_in = '0;
    step();
    check("busy_rise", bus.ramp_busy, 1);
    for (int i = 0; i < 16; i++) begin
      pulse();
      check("ramp_up_busy", bus.ramp_busy, (i < 15) ? 1 : 0);
      step();
    end
    check("idle_level", $signed(bus.level_out), 0);
    // 33 edges since release; idle dac is 1 on odd edges from the 2nd on
    n = 33;
    for (int i = 0; i < 6; i++) begin
      step();
      n++;
      check("idle_dac", bus.dac_out, n % 2);
    end

    // positive full scale, latency and density
    bus.sound_in = 11'(1023);
    pulse();
    step();
    check("pos_before_lat", $signed(bus.level_out), 0);
    step();
    check("pos_full", $signed(bus.level_out), 15345);
    for (int i = 0; i < 3; i++) step();
    ones = 0;
    for (int i = 0; i < 65536; i++) begin
      step();
      ones += int'(bus.dac_out);
    end
    tests++;
    if (ones < 48112 || ones > 48114) begin
      fails++;
      $display("FAIL dac_density: ones %0d, expected 48113 +/-1", ones);
    end

    // vector table at unity gain
    foreach (vecs[i]) begin
      bus.sound_in = 11'(vecs[i].snd);
      bus.volume   = 4'(vecs[i].vol);
      pulse();
      step();
      step();
      check("vec_level", $signed(bus.level_out), vecs[i].lvl);
    end

    // negative full scale, then volume 0 takes effect without a ramp
    bus.sound_in = 11'(-1024);
    bus.volume   = 4'd15;
    pulse();
    step();
    step();
    check("neg_full", $signed(bus.level_out), -15360);
    bus.volume = 4'd0;
    step();
    check("vol0_hold", $signed(bus.level_out), -15360);
    step();
    check("vol0_level", $signed(bus.level_out), 0);

    // ramp down to gain 8: -1 * 8 / 16 floors to -1
    bus.mute      = 1'b1;
    bus.sound_in  = 11'(-1);
    bus.volume    = 4'd1;
    bus.sample_en = 1'b1;
    step();
    bus.sample_en = 1'b0;
    check("down_busy", bus.ramp_busy, 1);
    for (int i = 0; i < 8; i++) pulse();
    step();
    step();
    check("half_gain_floor", $signed(bus.level_out), -1);
    for (int i = 0; i < 8; i++) begin
      pulse();
      check("ramp_down_busy", bus.ramp_busy, (i < 7) ? 1 : 0);
    end
    step();
    step();
    check("muted_level", $signed(bus.level_out), 0);

    // mute during ramp-up after 8 steps
    bus.sound_in  = 11'(1000);
    bus.volume    = 4'd15;
    bus.mute      = 1'b0;
    bus.sample_en = 1'b1;
    step();
    bus.sample_en = 1'b0;
    for (int i = 0; i < 8; i++) pulse();
    step();
    step();
    check("up8_level", $signed(bus.level_out), 7500);
    bus.mute      = 1'b1;
    bus.sample_en = 1'b1;
    step();
    bus.sample_en = 1'b0;
    step();
    check("rev_no_step", $signed(bus.level_out), 7500);
    check("rev_busy", bus.ramp_busy, 1);
    for (int i = 0; i < 8; i++) begin
      pulse();
      check("rev_down_busy", bus.ramp_busy, (i < 7) ? 1 : 0);
    end
    step();
    step();
    check("rev_muted_level", $signed(bus.level_out), 0);

    // reset in ACTIVE, then a fresh full ramp
    bus.mute = 1'b0;
    step();
    for (int i = 0; i < 16; i++) pulse();
    check("active_busy", bus.ramp_busy, 0);
    step();
    step();
    check("active_level", $signed(bus.level_out), 15000);
    reset = 1'b1;
    step();
    check("mid_rst_level", $signed(bus.level_out), 0);
    check("mid_rst_dac", bus.dac_out, 0);
    check("mid_rst_busy", bus.ramp_busy, 0);
    reset = 1'b0;
    step();
    check("rearm_busy", bus.ramp_busy, 1);
    for (int i = 0; i < 16; i++) begin
      pulse();
      check("rearm_ramp_busy", bus.ramp_busy, (i < 15) ? 1 : 0);
    end
    step();
    step();
    check("rearm_level", $signed(bus.level_out), 15000);

    // randomized traffic, compared every cycle by step()
    for (int i = 0; i < 4000; i++) begin
      bus.sample_en = ($urandom_range(0, 3) == 0);
      bus.sound_in  = 11'($urandom);
      bus.volume    = 4'($urandom);
      if ($urandom_range(0, 99) == 0) bus.mute = ~bus.mute;
      reset = ($urandom_range(0, 699) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ip_scc_sound_dac.md
# ip_scc_sound_dac

Audio back end for the SCC cartridge. Takes the 11-bit signed digital sound word from the SCC wrapper, applies volume and a click-free mute ramp, and drives a first-order delta-sigma 1-bit DAC output pin. Sits directly downstream of the SCC wrapper's `sound_out`, sharing its `clk` and sample strobe.

## Interface
Parameters:
- `SOUND_WIDTH`, 11: width of the signed input sample.
- `LEVEL_WIDTH`, 16: width of the signed scaled level and the DAC accumulator data path.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock, same clock as the SCC core.
- `reset`, in, 1: synchronous, active-high.
- `sample_en`, in, 1: one-`clk` strobe, one per SCC sample; the inverse of `mclk_pcen_n`.
- `sound_in`, in, 11: signed two's-complement SCC output.
- `volume`, in, 4: unsigned gain, 0 to 15; 0 is silent.
- `mute`, in, 1: level request; 1 ramps to silence, 0 ramps to full.
- `level_out`, out, 16: signed scaled level, registered.
- `dac_out`, out, 1: delta-sigma bitstream, registered.
- `ramp_busy`, out, 1: high while in RAMP_UP or RAMP_DOWN.

## Operation
- **Capture.** On `sample_en`, `ff_sample <= sound_in`. It holds otherwise.
- **Stage 1.** Every `clk`, `ff_p1 <= ff_sample * volume`. This is signed × unsigned and gives 15 bits signed. The range is −15360 to +15345.
- **Stage 2.** Every `clk`, `level_out <= (ff_p1 * gain) >>> 4`.
  - `gain` is 5-bit unsigned, 0 to 16.
  - The intermediate product is 20 bits signed.
  - The shift is arithmetic, truncating toward −∞.
  - The result is sign-extended to 16 bits and never saturates.
- **DAC.** `u = level_out ^ 16'h8000` (offset binary).
  - Accumulator: `acc[16:0] <= {1'b0, acc[15:0]} + u` every `clk`.
  - `dac_out <= acc[16]`.
  - Ones density is u/65536.
- **Ramp FSM.** States are MUTED, RAMP_UP, ACTIVE and RAMP_DOWN. Reset state is MUTED with `gain = 0`.
  - MUTED: `!mute` → RAMP_UP.
  - RAMP_UP: on `sample_en`, `gain++`. On the edge where `gain` becomes 16, the state becomes ACTIVE. If `mute` = 1 → RAMP_DOWN, with no gain step on that edge.
  - ACTIVE: `mute` → RAMP_DOWN.
  - RAMP_DOWN: on `sample_en`, `gain--`. On the edge where `gain` becomes 0, the state becomes MUTED. If `mute` = 0 → RAMP_UP, with no gain step on that edge.
- **Simultaneous events.** A direction change takes priority over a `sample_en` step on the same edge. `gain` never leaves the range 0 to 16.
- **Volume changes.** These take effect immediately, with no ramp.

## Timing
- **Reset values.** The following are all 0 on the first edge with `reset` high:
  - `level_out`, `dac_out`, `ramp_busy`, `acc`, `ff_sample`, `ff_p1`, `gain`.
- **Reset mid-operation.** Reset overrides everything. The FSM returns to MUTED even in the middle of a ramp.
- **Latency.** From the `sample_en` edge to `level_out` is 3 `clk` (capture, stage 1, stage 2). `dac_out` reflects a level change 2 `clk` later.
- **Ramp length.** A full ramp takes exactly 16 `sample_en` pulses. `ramp_busy` rises 1 `clk` after `mute` changes and falls on the edge where `gain` reaches its bound.
- **Idle output.** With `level_out = 0`, u = 32768, so `dac_out` toggles every `clk` after the first edge.

## Structure
- **Package `ip_scc_sound_dac_pkg`:**
  - FSM state encoding (2 bits: MUTED = 0, RAMP_UP = 1, ACTIVE = 2, RAMP_DOWN = 3).
  - `GAIN_MAX = 16`.
  - Width constants.
- **Sub-module `ip_delta_sigma_1st`:** holds the accumulator and `dac_out`, with parameter `WIDTH = LEVEL_WIDTH`. It is reusable for the PSG and OPLL paths.
- **Top level:** the FSM, the capture register and the two multiply stages.

## Test plan
- **Reset, then ramp up.** Stimulus: `mute` = 0, `volume` = 15, `sound_in` = 0, then 16 `sample_en` pulses. Required: `ramp_busy` is high for the ramp and falls on the 16th pulse; `level_out` = 0; `dac_out` alternates 0/1.
- **Positive full scale.** Stimulus: ACTIVE, `sound_in` = +1023, `volume` = 15. Required: `level_out` = 15345 three clocks after `sample_en`; `dac_out` ones count over 65536 clocks = 48113 ±1.
- **Negative full scale and volume zero.** Stimulus: `sound_in` = −1024, `volume` = 15. Required: `level_out` = −15360. Then `volume` = 0. Required: `level_out` = 0 two clocks later.
- **Partial gain.** Stimulus: `sound_in` = −1, `volume` = 1, `gain` = 8. Required: `level_out` = −1 (arithmetic shift floor).
- **Mute during ramp-up.** Stimulus: assert `mute` after 8 `sample_en` steps. Required: RAMP_DOWN, and 8 further pulses return to MUTED with `gain` = 0; there is no step on the reversal edge.
- **Reset mid-ACTIVE.** Stimulus: assert `reset` while ACTIVE. Required: all outputs 0 on the next edge; after release with `mute` = 0, a fresh 16-pulse ramp.
